// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO read-side arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Width of a consumer index; never narrower than one bit.
    function automatic int req_idx_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Width of a burst counter that must be able to hold max_burst itself.
    function automatic int burst_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after i_last, wrapping.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Walk priority offsets 1..NUM_REQ; the first hit wins and masks later ones.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!o_any && (j == (int'(i_last) + k) % NUM_REQ) && i_req[j]) begin
                    o_any    = 1'b1;
                    o_gnt[j] = 1'b1;
                    o_idx    = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin, burst-bounded read-port sharing with a one-deep output register.
// Optional transfer counter enabled by defining FIFO_RD_ARB_STATS_EN.
module fifo_read_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rempty,
    input  logic [DATA_W-1:0]  rdata,
    output logic               rinc,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rdy,
    output logic [NUM_REQ-1:0] gnt,
    output logic               vld,
    output logic [DATA_W-1:0]  dout
`ifdef FIFO_RD_ARB_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [15:0]        xfer_cnt
`endif
);

    localparam int IDX_W = req_idx_w(NUM_REQ);
    localparam int CNT_W = burst_w(MAX_BURST);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [IDX_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_vld;
    logic [DATA_W-1:0]  r_dout;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_any;
    logic               w_req_g;
    logic               w_rdy_g;
    logic               w_pop;
    logic               w_xfer;
    logic               w_leave_serve;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req  (req),
        .i_last (r_last),
        .o_gnt  (w_arb_gnt),
        .o_idx  (w_arb_idx),
        .o_any  (w_arb_any)
    );

    // r_last doubles as the granted index while a grant is held.
    assign w_req_g = req[r_last];
    assign w_rdy_g = rdy[r_last];

    // NOTE: the pop strobe is combinational so the FIFO pointer moves in the
    // same cycle the word is captured; registering it would pop one word late.
    assign w_pop  = (r_state == SERVE) && !rempty && w_req_g &&
                    (r_cnt < MAX_CNT) && (!r_vld || w_rdy_g);
    assign w_xfer = r_vld && w_rdy_g;

    assign w_leave_serve = (w_pop && (r_cnt == LAST_CNT)) || (r_cnt >= MAX_CNT) ||
                           !w_req_g || (rempty && !w_pop);

    assign rinc = w_pop;
    assign gnt  = r_gnt;
    assign vld  = r_vld;
    assign dout = r_dout;

    // NOTE: all state here uses non-blocking assignments so every read in this
    // block sees the pre-edge value, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= LAST_RST;
            r_cnt   <= '0;
            r_vld   <= 1'b0;
            r_dout  <= '0;
        end else begin
            if (w_pop) begin
                r_dout <= rdata;
                r_vld  <= 1'b1;
                r_cnt  <= r_cnt + 1'b1;
            end else if (w_xfer) begin
                r_vld  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_arb_any && !rempty) begin
                        r_gnt   <= w_arb_gnt;
                        r_last  <= w_arb_idx;
                        r_cnt   <= '0;
                        r_state <= SERVE;
                    end
                end
                SERVE: begin
                    if (w_leave_serve) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Grant is held until the pending word reaches its consumer.
                    if (!r_vld) begin
                        r_gnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_RD_ARB_STATS_EN
    logic [15:0] r_xfer_cnt;

    // Clear wins over a coincident transfer; the count saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_cnt <= '0;
        end else if (stats_clr) begin
            r_xfer_cnt <= '0;
        end else if (w_xfer && (r_xfer_cnt != 16'hFFFF)) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter with a FIFO model and a transfer scoreboard.
// Stats checks are compiled in when FIFO_RD_ARB_STATS_EN is defined.
module tb_fifo_read_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic              clk    = 1'b0;
    logic              rst    = 1'b1;
    logic              rempty = 1'b1;
    logic [DATA_W-1:0] rdata  = '0;
    logic              rinc;
    logic [NUM_REQ-1:0] req   = '0;
    logic [NUM_REQ-1:0] rdy   = '0;
    logic [NUM_REQ-1:0] gnt;
    logic              vld;
    logic [DATA_W-1:0] dout;
`ifdef FIFO_RD_ARB_STATS_EN
    logic              stats_clr = 1'b0;
    logic [15:0]       xfer_cnt;
`endif

    logic              wr_en   = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [NUM_REQ-1:0] gnt;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] fifo_q[$];
    int                xfer_cyc[$];

    int total   = 0;
    int bad     = 0;
    int n_pop   = 0;
    int n_xfer  = 0;
    int gnt_cyc = 0;
    int cyc     = 0;

    fifo_read_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .req       (req),
        .rdy       (rdy),
        .gnt       (gnt),
        .vld       (vld),
        .dout      (dout)
`ifdef FIFO_RD_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // FIFO model: pop on rinc, push on wr_en, flags visible after the edge.
    always @(posedge clk) begin
        if (rinc && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (wr_en) fifo_q.push_back(wr_data);
        rempty <= (fifo_q.size() == 0);
        rdata  <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    // Monitor: mid-cycle view of what the coming edge will do.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (rinc) begin
                n_pop++;
                check("no_underflow", 32'(rempty), 32'd0);
                check("rinc_granted", 32'(|gnt), 32'd1);
            end
            if (|gnt) gnt_cyc++;
            if (vld && |(gnt & rdy)) begin
                exp_t e;
                n_xfer++;
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", 32'(dout), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_data", 32'(dout), 32'(e.data));
                    check("xfer_gnt", 32'(gnt), 32'(e.gnt));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d, input logic [NUM_REQ-1:0] g, input bit track);
        wr_en   = 1'b1;
        wr_data = d;
        if (track) exp_q.push_back('{data: d, gnt: g});
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || gnt != '0) && n < max_cyc) begin
            tick(1);
            n++;
        end
        check(tag, 32'(n < max_cyc), 32'd1);
    endtask

    task automatic wait_vld(input string tag, input int max_cyc);
        int n = 0;
        while (!vld && n < max_cyc) begin
            tick(1);
            n++;
        end
        check(tag, 32'(vld), 32'd1);
    endtask

    initial begin
        int g0, p0, x0, n;

        // Reset values, then an empty FIFO must never be granted.
        req = 4'b0001;
        rdy = 4'b0001;
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_vld", 32'(vld), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rinc", 32'(rinc), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("empty_no_gnt", 32'(gnt), 32'd0);
            check("empty_no_rinc", 32'(rinc), 32'd0);
        end
        @(posedge clk); #1;
        g0 = gnt_cyc;
        p0 = n_pop;
        push_word(8'hA5, 4'b0001, 1'b1);
        wait_idle("t1_done", 20);
        check("t1_pops", 32'(n_pop - p0), 32'd1);
        check("t1_gnt_cycles", 32'(gnt_cyc - g0), 32'd3);

        // Four full bursts in round-robin order, back-to-back inside each burst.
        req = '0;
        rdy = 4'b1111;
        do_reset();
        for (int i = 0; i < 16; i++) push_word(8'h10 + 8'(i), 4'(1 << (i / 4)), 1'b1);
        x0 = xfer_cyc.size();
        g0 = gnt_cyc;
        req = 4'b1111;
        wait_idle("t2_done", 120);
        req = '0;
        check("t2_xfers", 32'(xfer_cyc.size() - x0), 32'd16);
        check("t2_gnt_cycles", 32'(gnt_cyc - g0), 32'd24);
        if (xfer_cyc.size() >= x0 + 16) begin
            for (int k = 1; k < 16; k++)
                check("t2_xfer_gap", 32'(xfer_cyc[x0+k] - xfer_cyc[x0+k-1]), (k % 4 == 0) ? 32'd4 : 32'd1);
        end

        // Consumer stall mid-burst: output held, no pops.
        rdy = 4'b0010;
        for (int i = 0; i < 4; i++) push_word(8'h20 + 8'(i), 4'b0010, 1'b1);
        x0 = n_xfer;
        p0 = n_pop;
        req = 4'b0010;
        n = 0;
        while (n_xfer - x0 < 2 && n < 30) begin
            tick(1);
            n++;
        end
        check("t3_reach_stall", 32'(n < 30), 32'd1);
        rdy = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_vld", 32'(vld), 32'd1);
            check("t3_stall_dout", 32'(dout), 32'h22);
            check("t3_stall_rinc", 32'(rinc), 32'd0);
        end
        @(posedge clk); #1;
        rdy = 4'b0010;
        wait_idle("t3_done", 30);
        req = '0;
        check("t3_pops", 32'(n_pop - p0), 32'd4);

        // Short FIFO: burst ends on empty, not on MAX_BURST.
        rdy = 4'b0001;
        push_word(8'h31, 4'b0001, 1'b1);
        push_word(8'h32, 4'b0001, 1'b1);
        p0 = n_pop;
        g0 = gnt_cyc;
        req = 4'b0001;
        wait_idle("t4_done", 30);
        req = '0;
        check("t4_pops", 32'(n_pop - p0), 32'd2);
        check("t4_gnt_cycles", 32'(gnt_cyc - g0), 32'd4);

`ifdef FIFO_RD_ARB_STATS_EN
        stats_clr = 1'b1;
        tick(1);
        stats_clr = 1'b0;
        for (int i = 0; i < 10; i++) push_word(8'h50 + 8'(i), 4'b0001, 1'b1);
        req = 4'b0001;
        wait_idle("st_done", 80);
        check("st_count10", 32'(xfer_cnt), 32'd10);
        rdy = '0;
        push_word(8'h5A, 4'b0001, 1'b1);
        wait_vld("st_clr_vld", 20);
        rdy = 4'b0001;
        stats_clr = 1'b1;
        tick(1);
        stats_clr = 1'b0;
        check("st_clr_with_xfer", 32'(xfer_cnt), 32'd0);
        wait_idle("st_clr_done", 20);
        force dut.r_xfer_cnt = 16'hFFFF;
        #1;
        release dut.r_xfer_cnt;
        push_word(8'h5B, 4'b0001, 1'b1);
        wait_idle("st_sat_done", 20);
        check("st_saturate", 32'(xfer_cnt), 32'h0000_FFFF);
        req = '0;
`endif

        // Request drop with a word pending: still delivered to consumer 1.
        rdy = '0;
        push_word(8'h40, 4'b0010, 1'b1);
        push_word(8'h41, 4'b0100, 1'b0);
        p0 = n_pop;
        req = 4'b0010;
        wait_vld("t5_vld", 20);
        req = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_hold_gnt", 32'(gnt), 32'b0010);
            check("t5_hold_vld", 32'(vld), 32'd1);
            check("t5_hold_dout", 32'(dout), 32'h40);
        end
        @(posedge clk); #1;
        rdy = 4'b0010;
        wait_idle("t5_done", 20);
        check("t5_gnt_clear", 32'(gnt), 32'd0);
        check("t5_pops", 32'(n_pop - p0), 32'd1);

        // Asynchronous reset mid-burst discards the held word at once.
        rdy = '0;
        req = 4'b0100;
        wait_vld("t6_vld", 20);
        check("t6_gnt", 32'(gnt), 32'b0100);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_gnt", 32'(gnt), 32'd0);
        check("t6_rst_vld", 32'(vld), 32'd0);
        check("t6_rst_dout", 32'(dout), 32'd0);
        check("t6_rst_rinc", 32'(rinc), 32'd0);
        @(posedge clk); #1;
        req = '0;
        rst = 1'b0;
        tick(2);
        check("t6_post_vld", 32'(vld), 32'd0);
        check("t6_post_gnt", 32'(gnt), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_read_arbiter.md
# fifo_read_arbiter

Read-side controller for the asynchronous FIFO. It shares the single FIFO read port between `NUM_REQ` consumers using round-robin grants with bounded bursts. It generates `rinc` from the read-domain empty flag and registers each popped word into a one-deep output stage with a valid/ready handshake. It sits in the read clock domain, between the FIFO read pointer/empty logic and the downstream consumers.

## Interface
- `NUM_REQ`, 4: number of consumers (2..16).
- `DATA_W`, 8: FIFO word width.
- `MAX_BURST`, 4: maximum pops per grant (1..255).
- `clk` in 1: read-domain clock.
- `rst` in 1: asynchronous, active-high reset.
- `rempty` in 1: FIFO empty flag, read domain. Deasserts only after a write is synchronized.
- `rdata` in DATA_W: FIFO word at the current read address, combinationally valid.
- `rinc` out 1: pop strobe to the FIFO read pointer.
- `req` in NUM_REQ: per-consumer request, level.
- `rdy` in NUM_REQ: per-consumer ready.
- `gnt` out NUM_REQ: one-hot grant, or zero.
- `vld` out 1: `dout` holds a word for the granted consumer.
- `dout` out DATA_W: registered output word.

## Operation
- FSM states IDLE, SERVE, DRAIN. Reset state is IDLE.
- Reset values: `gnt`=0, `vld`=0, `dout`=0, `rinc`=0, burst count 0, round-robin pointer `last`=NUM_REQ-1, so req[0] wins first.
- IDLE: when `|req` and !`rempty`, select the first set req at index (last+1) mod NUM_REQ upward, wrapping. Load `gnt`, set `last`, clear the burst count, and go to SERVE.
- SERVE, pop condition: !`rempty` && req[g] && count<MAX_BURST && (!`vld` || `rdy[g]`).
- SERVE, pop effect: `rinc`=1 (combinational, same cycle), `dout`<=`rdata`, `vld`<=1, count++.
- Transfer occurs when `vld` && `rdy[g]`. On a transfer with no simultaneous pop, `vld`<=0.
- Leave SERVE for DRAIN when count reaches MAX_BURST, req[g] drops, or `rempty` is seen while no pop occurs.
- DRAIN: no pops. Hold `gnt` until `vld`=0, then drop `gnt`, go to IDLE, and re-arbitrate the next cycle.
- A pending word is always delivered to the consumer it was popped for, even after that consumer's req drops.
- `rinc` is never asserted when `rempty`=1 (no underflow) and never asserted outside SERVE.

## Timing
- Pop-to-`vld` latency is 1 cycle: `rinc` in cycle k, `dout`/`vld` valid at the edge ending cycle k.
- Back-to-back throughput is 1 word/cycle while `rdy[g]`=1 and FIFO data is present.
- Grant turnaround: DRAIN→IDLE is 1 cycle and IDLE→SERVE is 1 cycle, so at least 2 idle cycles between bursts.
- A burst of length B with `rdy` held high: `gnt` active B+2 cycles.
- `rempty` reflects the updated pointer in the cycle after `rinc`. No pop is speculative.
- Simultaneous transfer and pop: `vld` stays 1 and `dout` is replaced.
- A reset mid-burst clears all state immediately. A word held in `dout` is discarded (already popped).

## Configuration
- `FIFO_RD_ARB_STATS_EN` defined: adds output `xfer_cnt` [15:0] and input `stats_clr` [1].
  - `xfer_cnt` counts completed transfers, saturates at 16'hFFFF, and is cleared by `stats_clr` or `rst`.
  - If `stats_clr` and a transfer occur in the same cycle, the result is 0.
- Undefined: neither port exists. No counter logic.

## Structure
- Package `fifo_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, SERVE, DRAIN};
  - `REQ_IDX_W` = $clog2(NUM_REQ) helper;
  - `BURST_W` = $clog2(MAX_BURST+1) helper.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req` and `last`. Returns a one-hot grant and an index.
- The FSM, burst counter and output register stay in the top module.

## Test plan
- Reset with req=4'b0001 held and FIFO empty: `gnt`=0 and `rinc`=0 until 1 word is written. Then gnt=4'b0001, 1 pop, dout=written value, then DRAIN and IDLE.
- req=4'b1111, FIFO preloaded with 16 words, all rdy=1: grants in order 0,1,2,3, each with 4 pops. Words delivered in FIFO order with no gaps inside a burst.
- rdy[g] low for 3 cycles mid-burst: `vld` and `dout` held stable, `rinc`=0 during the stall, and no words lost or duplicated.
- FIFO holds 2 words, MAX_BURST=4: 2 pops, `rempty` seen, DRAIN; `rinc` is never asserted while `rempty`=1.
- req[1] drops with a word pending: the word is still delivered on rdy[1], then `gnt` clears. `rst` pulsed mid-burst: all outputs return to reset values the same cycle.
- With `FIFO_RD_ARB_STATS_EN`: 10 transfers give xfer_cnt=10. `stats_clr` together with a transfer gives 0. Forcing 16'hFFFF plus 1 transfer holds at 16'hFFFF.
